// File: rtl/boot_pkg.sv
// boot_pkg: shared state encoding and handshake widths for the program loader
package boot_pkg;
    typedef enum logic [2:0] {IDLE, ROM_RD, WR, VRD, CHECK, DONE, ERROR} boot_state_t;
    localparam int WORD_BYTES = 4;
    localparam logic [31:0] DEFAULT_LOAD_BASE = 32'h0000_0000;
    localparam int ROM_ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int IDX_W = 16;
endpackage

// File: rtl/program_load_ctrl_if.sv
// program_load_ctrl_if: boot ROM read port plus RAM request/ready handshake
interface program_load_ctrl_if #(parameter int ADDR_W = 32);
    import boot_pkg::*;
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_rdata;
    logic mem_req;
    logic mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    modport master (
        output rom_addr, mem_req, mem_we, mem_addr, mem_wdata,
        input rom_rdata, mem_ready, mem_rdata
    );
    modport slave (
        input rom_addr, mem_req, mem_we, mem_addr, mem_wdata,
        output rom_rdata, mem_ready, mem_rdata
    );
endinterface

// File: rtl/load_checksum.sv
// load_checksum: 32-bit modular accumulator with synchronous clear
module load_checksum import boot_pkg::*; (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic add,
    input  logic [DATA_W-1:0] val,
    output logic [DATA_W-1:0] sum
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sum <= '0;
        else if (clr) sum <= '0;
        else if (add) sum <= sum + val;
endmodule

// File: rtl/program_load_ctrl.sv
// program_load_ctrl: copies the boot image ROM->RAM, verifies it by checksum, then releases the CPU
module program_load_ctrl import boot_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int IMG_WORDS = 256,
    parameter logic [31:0] LOAD_BASE = DEFAULT_LOAD_BASE,
    parameter bit VERIFY = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    program_load_ctrl_if.master bus,
    output logic cpu_rst_n,
    output logic loading_complete,
    output logic load_error,
    output logic [IDX_W-1:0] load_index
);
    boot_state_t state;
    logic [IDX_W-1:0] idx;
    logic [DATA_W-1:0] wr_sum, rd_sum;
    logic [ADDR_W-1:0] word_addr;
    logic last, wr_add, rd_add, clr;
    assign last = idx == IDX_W'(IMG_WORDS - 1);
    assign word_addr = ADDR_W'(LOAD_BASE) + ADDR_W'(32'(idx) * WORD_BYTES);
    assign wr_add = state == WR && bus.mem_req && bus.mem_ready;
    assign rd_add = state == VRD && bus.mem_req && bus.mem_ready;
    assign clr = state == IDLE;
    assign load_index = idx;
    load_checksum u_wr_sum (.clk(clk), .rst_n(rst_n), .clr(clr), .add(wr_add), .val(bus.mem_wdata), .sum(wr_sum));
    load_checksum u_rd_sum (.clk(clk), .rst_n(rst_n), .clr(clr), .add(rd_add), .val(bus.mem_rdata), .sum(rd_sum));
    // each word is a two-step handshake: issue with mem_req low, complete on mem_ready
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            idx <= '0;
            bus.rom_addr <= '0;
            bus.mem_req <= 1'b0;
            bus.mem_we <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_wdata <= '0;
            cpu_rst_n <= 1'b0;
            loading_complete <= 1'b0;
            load_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                    bus.rom_addr <= '0;
                    if (IMG_WORDS == 0 && !VERIFY) begin
                        loading_complete <= 1'b1;
                        cpu_rst_n <= 1'b1;
                    end
                    state <= IMG_WORDS == 0 ? (VERIFY ? CHECK : DONE) : ROM_RD;
                end
                ROM_RD: state <= WR;
                WR:
                    if (!bus.mem_req) begin
                        bus.mem_req <= 1'b1;
                        bus.mem_we <= 1'b1;
                        bus.mem_addr <= word_addr;
                        bus.mem_wdata <= bus.rom_rdata;
                    end else if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        bus.rom_addr <= idx + 1'b1;
                        idx <= last ? '0 : idx + 1'b1;
                        if (last && !VERIFY) begin
                            loading_complete <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end
                        state <= !last ? ROM_RD : VERIFY ? VRD : DONE;
                    end
                VRD:
                    if (!bus.mem_req) begin
                        bus.mem_req <= 1'b1;
                        bus.mem_we <= 1'b0;
                        bus.mem_addr <= word_addr;
                    end else if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        idx <= last ? '0 : idx + 1'b1;
                        state <= last ? CHECK : VRD;
                    end
                CHECK:
                    if (rd_sum == wr_sum) begin
                        state <= DONE;
                        loading_complete <= 1'b1;
                        cpu_rst_n <= 1'b1;
                    end else begin
                        state <= ERROR;
                        load_error <= 1'b1;
                    end
                DONE:
                    if (reload) begin
                        state <= IDLE;
                        loading_complete <= 1'b0;
                        cpu_rst_n <= 1'b0;
                    end
                ERROR:
                    if (reload) begin
                        state <= IDLE;
                        load_error <= 1'b0;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule
